// File: rtl/pipe_ifq.sv
// pipe_ifq: instruction fetch queue.
// Holds a fetch PC, issues fetch requests to instruction memory and buffers the
// returned {pc, instruction} pairs in a small circular FIFO for the decode stage.
//
// Ports:
//   clk_i          clock, all state updates on its rising edge
//   rst_n_i        asynchronous active-low reset
//   redirect_i     flush the queue and load redirect_pc_i as the new fetch PC
//   redirect_pc_i  redirect target PC
//   fetch_valid_o  fetch request to instruction memory
//   fetch_pc_o     address of the current fetch
//   fetch_ready_i  memory accepts the fetch; inst_data_i is valid in the same cycle
//   inst_data_i    instruction word for fetch_pc_o
//   valid_o        head entry available to decode
//   ready_i        decode consumes the head entry
//   pc_data_o      PC of the head entry
//   inst_data_o    instruction of the head entry
//   count_o        number of queued entries
module pipe_ifq #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       fetch_valid_o,
  output logic [XLEN-1:0]            fetch_pc_o,
  input  logic                       fetch_ready_i,
  input  logic [XLEN-1:0]            inst_data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            pc_data_o,
  output logic [XLEN-1:0]            inst_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Storage is not reset; only entries covered by count_q are ever observed.
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];

  logic full, empty, enq, deq;

  always_comb begin
    full          = (count_q == CntW'(DEPTH));
    empty         = (count_q == '0);
    fetch_valid_o = !full && !redirect_i;
    valid_o       = !empty;
    enq           = fetch_valid_o && fetch_ready_i;
    // A redirect flushes the queue, so a same-edge pop is meaningless.
    deq           = valid_o && ready_i && !redirect_i;
    fetch_pc_o    = fetch_pc_q;
    count_o       = count_q;
    pc_data_o     = pc_mem_q[head_q];
    inst_data_o   = inst_mem_q[head_q];
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap to 0.
      if (enq) begin
        tail_d     = tail_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem_q[tail_q]   <= fetch_pc_q;
      inst_mem_q[tail_q] <= inst_data_i;
    end
  end

endmodule

// File: doc/pipe_ifq.md
PIPE_IFQ -- requirements
Module: pipe_ifq

Interface
REQ-001 SHALL provide parameter XLEN, default 32, width of PC and instruction words.
REQ-002 SHALL provide parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-003 SHALL provide parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL have clk_i  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have redirect_i  input  1  flush the queue and load a new fetch PC.
REQ-007 SHALL have redirect_pc_i  input  XLEN  target PC for the redirect.
REQ-008 SHALL have fetch_valid_o  output  1  fetch request to instruction memory.
REQ-009 SHALL have fetch_pc_o  output  XLEN  address of the current fetch.
REQ-010 SHALL have fetch_ready_i  input  1  memory accepts the fetch; inst_data_i is valid in the same cycle.
REQ-011 SHALL have inst_data_i  input  XLEN  instruction word for fetch_pc_o.
REQ-012 SHALL have valid_o  output  1  head entry available to decode.
REQ-013 SHALL have ready_i  input  1  decode consumes the head entry.
REQ-014 SHALL have pc_data_o  output  XLEN  PC of the head entry.
REQ-015 SHALL have inst_data_o  output  XLEN  instruction of the head entry.
REQ-016 SHALL have count_o  output  $clog2(DEPTH+1)  current number of entries.

Function
REQ-017 SHALL assert fetch_valid_o = !full && !redirect_i, with full = (count == DEPTH).
REQ-018 SHALL enqueue {fetch_pc_o, inst_data_i} at the tail on an edge where fetch_valid_o && fetch_ready_i.
REQ-019 SHALL advance the fetch PC by 4 (modulo 2^XLEN, wrap to 0) on each enqueue and hold it otherwise.
REQ-020 SHALL assert valid_o = (count != 0) and drive pc_data_o/inst_data_o from the head entry combinationally.
REQ-021 SHALL dequeue the head on an edge where valid_o && ready_i.
REQ-022 SHALL enqueue and dequeue in the same cycle when both fire, leaving count unchanged.
REQ-023 SHALL update count as +1 on enqueue only and -1 on dequeue only; no change otherwise.
REQ-024 SHALL keep head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-025 SHALL give redirect_i priority over every other event: on that edge the head, tail and count go to 0, the fetch PC loads redirect_pc_i, and no enqueue occurs.
REQ-026 SHALL ignore a same-cycle dequeue during redirect, so ready_i has no effect on that edge.
REQ-027 SHALL never enqueue while full, never dequeue while empty, and never overwrite an unconsumed entry.
REQ-028 SHALL take fetch_ready_i into account only when fetch_valid_o is high.
REQ-029 SHALL drive pc_data_o/inst_data_o with don't-care values while valid_o is low; the bench does not check them then.
REQ-030 SHALL give a fetch-to-valid_o latency of 1 cycle when the queue is empty.

Reset
REQ-031 SHALL on rst_n_i low, immediately and independently of the clock: fetch PC = RESET_PC, head = tail = count = 0, valid_o = 0.
REQ-032 SHALL drive fetch_valid_o = 1 (unless redirect_i is high) and fetch_pc_o = RESET_PC from the first cycle after reset deasserts.
REQ-033 SHALL, when reset is asserted mid-operation, discard all queued entries with no residual valid_o.
REQ-034 SHALL not reset the storage array.

Verification
REQ-035 SHALL cover reset then fetch_ready_i = 1 with ready_i = 0 (DEPTH = 4): enqueue PCs 0x0, 0x4, 0x8, 0xC; count_o = 4; fetch_valid_o = 0; fetch_pc_o holds 0x10.
REQ-036 SHALL cover the queue full, then ready_i = 1 and fetch_ready_i = 1 held: one dequeue of PC 0x0 first; afterwards each cycle dequeues and enqueues together with count_o steady; output order is 0x0, 0x4, 0x8, ...
REQ-037 SHALL cover redirect_i = 1 with redirect_pc_i = 0x100 while count_o = 3 and ready_i = 1: next cycle count_o = 0, valid_o = 0, fetch_pc_o = 0x100; the following fetch shows pc_data_o = 0x100.
REQ-038 SHALL cover RESET_PC = 0xFFFFFFF8 with two enqueues: PCs 0xFFFFFFF8 and 0xFFFFFFFC are queued, then fetch_pc_o wraps to 0x0.
REQ-039 SHALL cover rst_n_i pulsed low mid-clock with 2 entries queued: valid_o drops without a clock edge; fetch_pc_o = RESET_PC; count_o = 0.
REQ-040 SHALL cover random fetch_ready_i/ready_i/redirect_i over 10k cycles against a reference FIFO model: no loss, duplication or reordering, and count_o always <= DEPTH.
